seg_mux_ctrl: RTL and testbench

SEG_MUX_CTRL -- requirements
Module: seg_mux_ctrl

---
 rtl/seg_mux_pkg.sv | 24 ++
 rtl/seg_mux_ctrl_if.sv | 23 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg_mux_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_mux_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_mux_pkg.sv
// Shared types and segment codes for the multiplexed 7-segment controller.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package seg_mux_pkg;

    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        SHOW_T  = 2'd1,
        BLANK_O = 2'd2,
        SHOW_O  = 2'd3
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_mux_ctrl_if.sv
// Digit-pair load channel: the producer offers a tens/ones pair with a valid/ready handshake.
interface seg_mux_ctrl_if;

    logic [3:0] tens_i;
    logic [3:0] ones_i;
    logic       load_valid;
    logic       load_ready;

    modport master (
        output tens_i,
        output ones_i,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  tens_i,
        input  ones_i,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder; non-decimal codes 10-15 render dark.
module seg7_decode
    import seg_mux_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_mux_ctrl.sv
// Two-digit multiplexed 7-segment refresh controller with a one-deep load buffer.
// Active digits only change at a frame boundary, so a frame never shows a torn pair.
module seg_mux_ctrl
    import seg_mux_pkg::*;
#(
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned DIV_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_mux_ctrl_if.slave    load_if,
    input  logic [DIV_W-1:0] refresh_div,
    input  logic             lz_en,
    output logic             digit_sel,
    output logic [6:0]       seg,
    output logic             frame_done
);

    localparam int unsigned     BW        = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0]   BlankLast = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;
    localparam state_e          RstState  = (BLANK_CYC == 0) ? SHOW_T : BLANK_T;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [3:0]       act_t_q, act_t_d, act_o_q, act_o_d;
    logic [3:0]       pend_t_q, pend_t_d, pend_o_q, pend_o_d;
    logic             pend_v_q, pend_v_d;
    logic [6:0]       seg_q, seg_d;
    logic             sel_q, fd_q;

    logic             show, dwell_done, boundary, accept;
    logic [DIV_W-1:0] limit;
    logic             tens_side, blank_st;
    logic [3:0]       digit;
    logic [6:0]       dec_seg;

    assign show   = (state_q == SHOW_T) || (state_q == SHOW_O);
    // The first SHOW cycle always has cnt_q == 0; that is where refresh_div is captured.
    assign limit  = (cnt_q == '0) ? refresh_div : div_q;
    assign dwell_done = show ? (cnt_q == limit) : (blank_q == BlankLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blank_d  = blank_q;
        div_d    = div_q;
        boundary = 1'b0;
        if (show) begin
            div_d = limit;
            cnt_d = cnt_q + DIV_W'(1);
        end else begin
            blank_d = blank_q + BW'(1);
        end
        if (dwell_done) begin
            cnt_d   = '0;
            blank_d = '0;
            unique case (state_q)
                BLANK_T: state_d = SHOW_T;
                SHOW_T:  state_d = (BLANK_CYC == 0) ? SHOW_O : BLANK_O;
                BLANK_O: state_d = SHOW_O;
                SHOW_O: begin
                    state_d  = (BLANK_CYC == 0) ? SHOW_T : BLANK_T;
                    boundary = 1'b1;
                end
                default: state_d = RstState;
            endcase
        end
    end

    assign accept             = load_if.load_valid && !pend_v_q;
    assign load_if.load_ready = !pend_v_q;

    always_comb begin
        act_t_d  = act_t_q;
        act_o_d  = act_o_q;
        pend_t_d = pend_t_q;
        pend_o_d = pend_o_q;
        pend_v_d = pend_v_q;
        if (boundary && pend_v_q) begin
            act_t_d  = pend_t_q;
            act_o_d  = pend_o_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pend_t_d = load_if.tens_i;
            pend_o_d = load_if.ones_i;
            pend_v_d = 1'b1;
        end
    end

    // Outputs are precomputed from next state so they come straight out of flops.
    assign tens_side = (state_d == BLANK_T) || (state_d == SHOW_T);
    assign blank_st  = (state_d == BLANK_T) || (state_d == BLANK_O);
    assign digit     = tens_side ? act_t_d : act_o_d;

    seg7_decode u_decode (
        .bcd_i (digit),
        .seg_o (dec_seg)
    );

    assign seg_d = (blank_st || (tens_side && lz_en && (act_t_d == 4'd0))) ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RstState;
            cnt_q    <= '0;
            div_q    <= '0;
            blank_q  <= '0;
            act_t_q  <= '0;
            act_o_q  <= '0;
            pend_t_q <= '0;
            pend_o_q <= '0;
            pend_v_q <= 1'b0;
            seg_q    <= SEG_BLANK;
            sel_q    <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            blank_q  <= blank_d;
            act_t_q  <= act_t_d;
            act_o_q  <= act_o_d;
            pend_t_q <= pend_t_d;
            pend_o_q <= pend_o_d;
            pend_v_q <= pend_v_d;
            seg_q    <= seg_d;
            sel_q    <= tens_side;
            fd_q     <= boundary;
        end
    end

    assign seg        = seg_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Scoreboard bench for seg_mux_ctrl: a phase/dwell reference model predicts every cycle's
// outputs into a queue that a separate negedge monitor drains and compares.
module tb_seg_mux_ctrl;

    localparam int BC = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       ds;
        logic       fd;
        logic       rdy;
    } exp_t;

    localparam exp_t RstExp = '{seg: 7'd0, ds: 1'b1, fd: 1'b0, rdy: 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] refresh_div = 8'd3;
    logic       lz_en = 1'b0;
    logic       digit_sel, frame_done;
    logic [6:0] seg;

    logic       rst2_n = 1'b0;
    logic [7:0] rd2 = 8'd0;
    logic       lz2 = 1'b0;
    logic       ds2, fd2;
    logic [6:0] seg2;
    bit         bc0_done = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    seg_mux_ctrl_if lf ();
    seg_mux_ctrl_if lf2 ();

    seg_mux_ctrl #(.BLANK_CYC(BC), .DIV_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_if     (lf),
        .refresh_div (refresh_div),
        .lz_en       (lz_en),
        .digit_sel   (digit_sel),
        .seg         (seg),
        .frame_done  (frame_done)
    );

    seg_mux_ctrl #(.BLANK_CYC(0), .DIV_W(8)) dut_bc0 (
        .clk         (clk),
        .rst_n       (rst2_n),
        .load_if     (lf2),
        .refresh_div (rd2),
        .lz_en       (lz2),
        .digit_sel   (ds2),
        .seg         (seg2),
        .frame_done  (fd2)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", nm, $time, got, exp);
        end
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference model: phase 0..3 = blank-tens, show-tens, blank-ones, show-ones.
    int   mph, mleft;
    bit   mfresh, mpv;
    int   mat, mao, mpt, mpo;

    task automatic mreset();
        mph    = (BC == 0) ? 1 : 0;
        mleft  = BC;
        mfresh = (BC == 0);
        mat = 0; mao = 0; mpt = 0; mpo = 0;
        mpv = 1'b0;
    endtask

    task automatic mstep();
        bit   acc, bnd, blank, tens;
        exp_t e;
        acc = lf.load_valid && !mpv;
        if (mfresh) begin
            mleft  = int'(refresh_div) + 1;
            mfresh = 1'b0;
        end
        mleft--;
        bnd = 1'b0;
        if (mleft == 0) begin
            if (mph == 3) bnd = 1'b1;
            mph = (mph + 1) % 4;
            if (BC == 0 && (mph == 0 || mph == 2)) mph++;
            if (mph == 0 || mph == 2) mleft = BC;
            else mfresh = 1'b1;
        end
        if (bnd && mpv) begin
            mat = mpt; mao = mpo; mpv = 1'b0;
        end
        if (acc) begin
            mpt = int'(lf.tens_i); mpo = int'(lf.ones_i); mpv = 1'b1;
        end
        blank = (mph == 0) || (mph == 2);
        tens  = (mph < 2);
        e.seg = (blank || (tens && lz_en && mat == 0)) ? 7'd0 : ref_seg(tens ? mat : mao);
        e.ds  = tens;
        e.fd  = bnd;
        e.rdy = !mpv;
        q.push_back(e);
    endtask

    // Model: predicts the cycle after this negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mreset();
            q.push_back(RstExp);
        end else begin
            mstep();
        end
    end

    // Monitor: every cycle the DUT presents a full output set.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t got none expected entry", $time);
        end else begin
            e = q.pop_front();
            chk("seg", seg, e.seg);
            chk("digit_sel", {6'd0, digit_sel}, {6'd0, e.ds});
            chk("frame_done", {6'd0, frame_done}, {6'd0, e.fd});
            chk("load_ready", {6'd0, lf.load_ready}, {6'd0, e.rdy});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] t, input logic [3:0] o);
        bit took = 1'b0;
        lf.tens_i     = t;
        lf.ones_i     = o;
        lf.load_valid = 1'b1;
        for (int i = 0; i < 2000 && !took; i++) begin
            took = lf.load_ready;
            tick(1);
        end
        lf.load_valid = 1'b0;
        checks++;
        if (!took) begin
            errors++;
            $display("FAIL load_timeout got ready=0 expected accept of %0d,%0d", t, o);
        end
    endtask

    initial begin
        bit found;
        lf.tens_i = 4'd0;
        lf.ones_i = 4'd0;
        lf.load_valid = 1'b0;
        q.push_back(RstExp);
        tick(3);
        rst_n = 1'b1;
        tick(30);                       // idle frames, digits 0
        tick(4);
        load(4'd2, 4'd3);
        tick(30);
        load(4'd5, 4'd1);               // back-to-back pair
        load(4'd7, 4'd8);
        tick(40);
        lz_en = 1'b1;
        load(4'd0, 4'd9);
        tick(30);
        load(4'd12, 4'd4);
        tick(14);
        lz_en = 1'b0;
        tick(20);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) refresh_div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            lf.load_valid = ($urandom_range(0, 3) == 0);
            lf.tens_i     = 4'($urandom_range(0, 15));
            lf.ones_i     = 4'($urandom_range(0, 15));
            tick(1);
        end
        lf.load_valid = 1'b0;
        lz_en = 1'b0;
        refresh_div = 8'd255;           // full-range dwell
        load(4'd9, 4'd6);
        tick(1100);
        refresh_div = 8'd1;
        tick(20);
        // Hold a pending pair while the display is in the ones dwell, then reset.
        lf.tens_i = 4'd6;
        lf.ones_i = 4'd6;
        lf.load_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mph == 3 && mpv) found = 1'b1;
            else tick(1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_window got no SHOW_O with pending expected one within 200 cycles");
        end
        rst_n = 1'b0;
        lf.load_valid = 1'b0;
        q.delete();
        q.push_back(RstExp);
        tick(3);
        rst_n = 1'b1;
        tick(40);
        for (int i = 0; i < 100 && !bc0_done; i++) tick(1);
        checks++;
        if (!bc0_done) begin
            errors++;
            $display("FAIL bc0_timeout got unfinished expected done");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Zero-blanking instance: every cycle alternates digits and digit 8 is always lit.
    initial begin
        logic prev;
        lf2.tens_i = 4'd0;
        lf2.ones_i = 4'd0;
        lf2.load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst2_n = 1'b1;
        lf2.tens_i = 4'd8;
        lf2.ones_i = 4'd8;
        lf2.load_valid = 1'b1;
        @(posedge clk);
        #1;
        lf2.load_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        prev = ds2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("bc0_toggle", {6'd0, ds2}, {6'd0, ~prev});
            chk("bc0_seg8", seg2, 7'b1111111);
            prev = ds2;
        end
        bc0_done = 1'b1;
    end

endmodule
